// File: rtl/display_mux_n.sv
// Time-multiplexed seven-segment scanner: per-slot prescaler, anode dead-time,
// PWM brightness, per-digit blanking and frame-synchronous (tear-free) input capture.
module display_mux_n #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 16,
    parameter int BRIGHT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7*DIGITS-1:0]   seg_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            sseg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int LEVELS = 1 << BRIGHT_W;
    localparam int SUB    = PRESCALE / LEVELS;
    localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W  = $clog2(DIGITS);

    generate
        if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
            $error("display_mux_n: DIGITS must be in 2..8");
        end
        if (PRESCALE < LEVELS || (PRESCALE % LEVELS) != 0) begin : g_bad_prescale
            $error("display_mux_n: PRESCALE must be a non-zero multiple of 2**BRIGHT_W");
        end
    endgenerate

    localparam logic [CNT_W:0] SUB_V = (CNT_W+1)'(SUB);
    localparam logic [CNT_W:0] ONE_V = (CNT_W+1)'(1);

    function automatic logic [6:0] seg_of(input logic [7*DIGITS-1:0] s,
                                          input logic [IDX_W-1:0]    i);
        seg_of = 7'h7F;
        for (int k = 0; k < DIGITS; k++) begin
            if (i == IDX_W'(k)) seg_of = s[7*k +: 7];
        end
    endfunction

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [7*DIGITS-1:0] r_seg_s;
    logic [DIGITS-1:0]   r_dp_s;
    logic [DIGITS-1:0]   r_blank_s;
    logic [BRIGHT_W-1:0] r_bright_s;

    logic [DIGITS-1:0]   r_an_p1;
    logic [6:0]          r_sseg_p1;
    logic                r_dp_p1;
    logic                r_frame_tick;

    logic                w_slot_end;
    logic                w_frame_end;
    logic [CNT_W:0]      w_limit;
    logic                w_on;

    assign w_slot_end  = (r_cnt == CNT_W'(PRESCALE-1));
    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS-1));

    // p0: slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(DIGITS-1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Shadows only move at the frame wrap so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s    <= '1;
            r_dp_s     <= '0;
            r_blank_s  <= '1;
            r_bright_s <= '0;
        end else if (w_frame_end) begin
            r_seg_s    <= seg_in;
            r_dp_s     <= dp_in;
            r_blank_s  <= blank;
            r_bright_s <= brightness;
        end
    end

    // cnt = 0 is the dead-time cycle; on-window ends at (bright+1)*SUB.
    assign w_limit = ((CNT_W+1)'(r_bright_s) + ONE_V) * SUB_V;
    assign w_on    = (r_cnt != '0) && ({1'b0, r_cnt} < w_limit) && !r_blank_s[r_idx];

    // p1: registered pin drive, one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_p1      <= '1;
            r_sseg_p1    <= 7'h7F;
            r_dp_p1      <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an_p1      <= w_on ? ~(DIGITS'(1) << r_idx) : '1;
            r_sseg_p1    <= w_on ? seg_of(r_seg_s, r_idx) : 7'h7F;
            r_dp_p1      <= w_on ? ~r_dp_s[r_idx] : 1'b1;
            r_frame_tick <= w_frame_end;
        end
    end

    assign an         = r_an_p1;
    assign sseg       = r_sseg_p1;
    assign dp         = r_dp_p1;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_mux_n.sv
// Scoreboard bench for display_mux_n: a frame/slot arithmetic model predicts pins
// for a 4-digit instance; an 8-digit instance runs a random soak for exclusivity and frame period.
module tb_display_mux_n;

    localparam int D   = 4;
    localparam int P   = 8;
    localparam int BW  = 2;
    localparam int F   = D * P;
    localparam int SUB = P / (1 << BW);
    localparam int D8  = 8;
    localparam int F8  = D8 * P;

    typedef struct {
        logic [D-1:0] an;
        logic [6:0]   sseg;
        logic         dp;
        logic         ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7*D-1:0] seg_in = '1;
    logic [D-1:0]   dp_in = '0;
    logic [D-1:0]   blank = '0;
    logic [BW-1:0]  brightness = '0;
    logic [D-1:0]   an;
    logic [6:0]     sseg;
    logic           dp;
    logic           frame_tick;

    logic [7*D8-1:0] seg8 = '1;
    logic [D8-1:0]   dp8 = '0;
    logic [D8-1:0]   blank8 = '0;
    logic [BW-1:0]   bright8 = '0;
    logic [D8-1:0]   an8;
    logic [6:0]      sseg8;
    logic            dpo8;
    logic            ft8;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q[$];
    bit   mon_en = 1'b0;

    // model state: cycles since reset release plus the frame's captured inputs
    int             m_k = 0;
    logic [7*D-1:0] m_seg;
    logic [D-1:0]   m_dp;
    logic [D-1:0]   m_blank;
    logic [BW-1:0]  m_bright;

    localparam logic [7*D-1:0] PAT = {7'h79, 7'h24, 7'h30, 7'h40};

    display_mux_n #(.DIGITS(D), .PRESCALE(P), .BRIGHT_W(BW)) u_dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dp_in(dp_in), .blank(blank),
        .brightness(brightness), .an(an), .sseg(sseg), .dp(dp), .frame_tick(frame_tick)
    );

    display_mux_n #(.DIGITS(D8), .PRESCALE(P), .BRIGHT_W(BW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg8), .dp_in(dp8), .blank(blank8),
        .brightness(bright8), .an(an8), .sseg(sseg8), .dp(dpo8), .frame_tick(ft8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_k      = 0;
        m_seg    = '1;
        m_dp     = '0;
        m_blank  = '1;
        m_bright = '0;
    endtask

    function automatic exp_t model_decode(int k);
        exp_t e;
        int   cnt;
        int   idx;
        bit   on;
        cnt = k % P;
        idx = (k / P) % D;
        on  = (cnt >= 1) && (cnt < (int'(m_bright) + 1) * SUB) && (m_blank[idx] == 1'b0);
        e.an   = '1;
        e.sseg = 7'h7F;
        e.dp   = 1'b1;
        e.ft   = 1'b0;
        if (on) begin
            e.an[idx] = 1'b0;
            e.sseg    = m_seg[idx*7 +: 7];
            e.dp      = ~m_dp[idx];
        end
        return e;
    endfunction

    // Called at a falling edge: drive inputs, predict the pins after the coming edge.
    task automatic step(input logic [7*D-1:0] s, input logic [D-1:0] d,
                        input logic [D-1:0] b, input logic [BW-1:0] br);
        exp_t e;
        seg_in     = s;
        dp_in      = d;
        blank      = b;
        brightness = br;
        e    = model_decode(m_k);
        e.ft = ((m_k + 1) % F == 0);
        q.push_back(e);
        if (m_k % F == F - 1) begin
            m_seg    = s;
            m_dp     = d;
            m_blank  = b;
            m_bright = br;
        end
        m_k++;
        @(negedge clk);
    endtask

    task automatic step_rand();
        step(28'($urandom()), 4'($urandom()), 4'($urandom()), 2'($urandom()));
    endtask

    // monitor: pops one prediction per clock and compares all pins
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && q.size() > 0) begin
                e = q.pop_front();
                check("an",         32'(an),         32'(e.an));
                check("sseg",       32'(sseg),       32'(e.sseg));
                check("dp",         32'(dp),         32'(e.dp));
                check("frame_tick", 32'(frame_tick), 32'(e.ft));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            seg8    = 56'({$urandom(), $urandom()});
            dp8     = 8'($urandom());
            blank8  = 8'($urandom());
            bright8 = 2'($urandom());
        end
    end

    initial begin
        int since;
        since = -1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                since = -1;
            end else begin
                check("an8_onehot", 32'($countones(~an8) <= 1), 32'd1);
                if (since >= 0) since++;
                if (ft8) begin
                    if (since >= 0) check("ft8_period", 32'(since), 32'(F8));
                    since = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_an",   32'(an),         32'hF);
        check("rst_sseg", 32'(sseg),       32'h7F);
        check("rst_dp",   32'(dp),         32'd1);
        check("rst_ft",   32'(frame_tick), 32'd0);

        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3 * F) step(PAT, 4'b0100, 4'b0000, 2'd3);
        repeat (2 * F) step(PAT, 4'b0100, 4'b0000, 2'd0);
        repeat (2 * F) step(PAT, 4'b0100, 4'b0000, 2'd1);
        repeat (2 * F) step(PAT, 4'b0100, 4'b0010, 2'd3);
        repeat (6 * F) step_rand();
        repeat (2 * F) step(PAT, 4'b0100, 4'b0000, 2'd3);
        while (m_k % F != 20) step(PAT, 4'b0100, 4'b0000, 2'd3);

        // pins now show digit 2 lit; reset must darken them without a clock edge
        check("pre_rst_an", 32'(an), 32'b1011);
        mon_en = 1'b0;
        q.delete();
        rst_n = 1'b0;
        #1;
        check("async_rst_an",   32'(an),         32'hF);
        check("async_rst_sseg", 32'(sseg),       32'h7F);
        check("async_rst_dp",   32'(dp),         32'd1);
        check("async_rst_ft",   32'(frame_tick), 32'd0);
        repeat (2) @(negedge clk);

        model_reset();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4 * F) step_rand();
        repeat (2 * F) step(PAT, 4'b1111, 4'b0000, 2'd2);

        @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_mux_n.md
# display_mux_n

Parametrised time-multiplexed seven-segment driver: scans DIGITS common-anode digits with a programmable per-slot prescaler, per-digit decimal point and blanking, PWM brightness, an anode dead-time against ghosting, and tear-free frame-synchronous input capture. It sits between the display-formatting logic (BCD/segment encoders) and the board's anode/segment pins, and replaces the fixed 4-digit, one-digit-per-clock scanner.

## Interface
- DIGITS, 4: number of digits scanned; legal 2..8.
- PRESCALE, 16: clock cycles per digit slot. It must be a multiple of 2^BRIGHT_W and at least 2^BRIGHT_W; any other value is an elaboration error.
- BRIGHT_W, 2: brightness code width.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7*DIGITS  active-low segment patterns; digit i uses bits [7i+6:7i].
- dp_in  in  DIGITS  decimal point request; 1 means the point is lit.
- blank  in  DIGITS  1 means digit i stays dark for its whole slot.
- brightness  in  BRIGHT_W  duty code; 0 is dimmest, all-ones is brightest.
- an  out  DIGITS  active-low anode enables.
- sseg  out  7  active-low segments.
- dp  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

## Operation
- State:
  - cnt, range 0..PRESCALE-1.
  - idx, range 0..DIGITS-1.
  - Shadow registers: seg_s, dp_s, blank_s, bright_s.
- Counting:
  - cnt increments every cycle.
  - When cnt = PRESCALE-1, cnt wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0, which starts a new frame.
- Shadow capture:
  - On the edge where idx wraps DIGITS-1→0, the shadow registers load seg_in, dp_in, blank and brightness.
  - They hold constant for the whole frame. Input changes mid-frame never appear before the next frame.
- Slot decode:
  - SUB = PRESCALE / 2^BRIGHT_W.
  - Digit idx is "on" when 1 ≤ cnt < (bright_s+1)*SUB and blank_s[idx] = 0.
  - cnt = 0 is always dead-time: all anodes are off.
- Output values:
  - When on: an has only bit idx low, sseg = seg_s[idx], dp = ~dp_s[idx].
  - When off: an is all ones, sseg = 7'h7F, dp = 1.
- frame_tick is high exactly in the cycle where state is cnt = 0, idx = 0, excluding the reset state itself.
- Reset (asynchronous, any time, including mid-slot):
  - cnt = 0, idx = 0.
  - seg_s = all ones, dp_s = 0, blank_s = all ones, bright_s = 0.
  - an = all ones, sseg = 7'h7F, dp = 1, frame_tick = 0.
  - Display is dark until the first frame boundary after reset release.
- At most one anode is ever low, in every cycle.

## Timing
- an, sseg and dp are registered. In cycle t they show the decode of the state (cnt, idx, shadows) of cycle t-1, so pins lag state by one cycle.
- frame_tick is registered and aligned with state, not pins.
- Slot length is exactly PRESCALE cycles. Frame length is exactly DIGITS*PRESCALE cycles.
- The first shadow capture happens at the edge ending cycle DIGITS*PRESCALE-1 after reset release; the first frame_tick follows it.
- On-time per slot is (bright_s+1)*SUB - 1 cycles, at state cnt 1..(bright_s+1)*SUB-1.
  - At maximum brightness this is PRESCALE-1 cycles.
  - At brightness 0 with SUB = 1 it is 0 cycles (digit dark).
- Inputs sampled in the same cycle as the wrap edge are the values captured.

## Test plan
- Reset/first frame: params DIGITS=4, PRESCALE=8, BRIGHT_W=2; hold rst_n low, then release.
  - Outputs must be an=4'hF, sseg=7'h7F, dp=1 for the first 32 cycles.
  - frame_tick must pulse once at cycle 32.
- Scan order and full brightness: brightness=3, blank=0, seg_in={7'h79,7'h24,7'h30,7'h40}, dp_in=4'b0100.
  - an follows 1110, 1101, 1011, 0111, each low for 7 cycles, separated by 1 all-off cycle.
  - sseg = 7'h40 on digit 0 and 7'h30 on digit 1.
  - dp low only on digit 2.
- PWM: brightness=0.
  - Each anode is low exactly 1 cycle per 8-cycle slot.
  - With brightness=1, it is low 3 cycles per slot.
- Blanking and tear-free update:
  - Set blank=4'b0010: digit 1's anode never goes low; the other digits are unaffected.
  - Change seg_in mid-frame: the pins keep the old pattern until the cycle after the next frame_tick.
- Reset mid-operation: drop rst_n during a lit slot of digit 2.
  - an=4'hF immediately, without waiting for a clock edge.
  - After release, the scan restarts at digit 0 and the display is dark for 32 cycles.
- Exclusivity: run a random-stimulus soak with DIGITS=8.
  - Assert an never has more than one bit low.
  - Assert frame_tick period = DIGITS*PRESCALE.
